// File: rtl/min_max_tree.sv
`default_nettype none
// ============================================================================
//  Module      : min_max_tree
//  Description : Pipelined N-lane minimum/maximum selector that also reports
//                the winning lane index. The lanes feed a binary compare tree
//                with one register stage per level. The mode is chosen per
//                sample, and valid/ready flow control stalls the whole
//                pipeline at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module min_max_tree #(
   parameter  int WIDTH  = 8,
   parameter  int N      = 3,
   parameter  int SIGNED = 0,
   localparam int L      = $clog2(N),
   localparam int IDXW   = (L < 1) ? 1 : L
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic                 mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [IDXW-1:0]      out_idx
);

   // The leaves are padded to a power of two. Padding entries are marked
   // not-present, so they never win. A real entry paired with a pad is
   // therefore an unpaired entry that passes through unchanged.
   localparam int P = 1 << L;

   // XOR-ing the sign bit maps a two's-complement order onto an unsigned order.
   localparam logic [WIDTH-1:0] C_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

   // Leaf entries (combinational from the input) and tree nodes in heap order.
   // Node 0 is the root. The children of node n are 2n+1 and 2n+2.
   logic [WIDTH-1:0] w_leaf_val [0:P-1];
   logic [IDXW-1:0]  w_leaf_idx [0:P-1];
   logic             w_leaf_prs [0:P-1];
   logic [WIDTH-1:0] r_node_val [0:P-2];
   logic [IDXW-1:0]  r_node_idx [0:P-2];
   logic             r_node_prs [0:P-2];

   // Bit k holds the valid flag for the sample in stage k+1.
   logic [L-1:0]     r_vld;
   // Bit k holds the mode that stage k+1 applies (bit 0 is the live input).
   logic [L-1:0]     w_md_chain;
   logic             w_adv;

   // Global stall: every stage moves only when the output slot can move.
   assign out_valid = r_vld[L-1];
   assign w_adv     = out_ready | ~out_valid;
   assign in_ready  = w_adv;
   assign out_data  = r_node_val[0];
   assign out_idx   = r_node_idx[0];

   for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < N) begin : g_lane
         assign w_leaf_val[i] = in_data[i*WIDTH +: WIDTH];
         assign w_leaf_prs[i] = 1'b1;
      end else begin : g_pad
         assign w_leaf_val[i] = '0;
         assign w_leaf_prs[i] = 1'b0;
      end
      assign w_leaf_idx[i] = IDXW'(i);
   end

   // Only the first L-1 stages need to remember the mode. The last stage
   // consumes the mode that was stored before it.
   if (L > 1) begin : g_mode_pipe
      logic [L-2:0] r_md;

      // Shift each sample's mode along with its data.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_md <= '0;
         end else if (w_adv) begin
            r_md[0] <= mode;
            for (int k = 1; k < L - 1; k++) begin
               r_md[k] <= r_md[k-1];
            end
         end
      end

      assign w_md_chain = {r_md, mode};
   end else begin : g_mode_direct
      assign w_md_chain = mode;
   end

   // Shift the valid flags. A bubble enters when no sample is offered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else if (w_adv) begin
         r_vld[0] <= in_valid;
         for (int k = 1; k < L; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   // Depth d of the heap is register stage L-d.
   for (genvar d = 0; d < L; d++) begin : g_lvl
      for (genvar p = 0; p < (1 << d); p++) begin : g_node
         localparam int C_NODE = (1 << d) - 1 + p;

         logic [WIDTH-1:0] w_a_val, w_b_val, w_a_key, w_b_key;
         logic [IDXW-1:0]  w_a_idx, w_b_idx;
         logic             w_a_prs, w_b_prs, w_mode, w_b_better, w_pick_b;

         if (d == L - 1) begin : g_from_leaf
            assign w_a_val = w_leaf_val[2*p];
            assign w_a_idx = w_leaf_idx[2*p];
            assign w_a_prs = w_leaf_prs[2*p];
            assign w_b_val = w_leaf_val[2*p+1];
            assign w_b_idx = w_leaf_idx[2*p+1];
            assign w_b_prs = w_leaf_prs[2*p+1];
         end else begin : g_from_node
            assign w_a_val = r_node_val[2*C_NODE+1];
            assign w_a_idx = r_node_idx[2*C_NODE+1];
            assign w_a_prs = r_node_prs[2*C_NODE+1];
            assign w_b_val = r_node_val[2*C_NODE+2];
            assign w_b_idx = r_node_idx[2*C_NODE+2];
            assign w_b_prs = r_node_prs[2*C_NODE+2];
         end

         // Apply the mode of the sample that this stage is consuming.
         assign w_mode     = w_md_chain[L-1-d];
         assign w_a_key    = w_a_val ^ C_FLIP;
         assign w_b_key    = w_b_val ^ C_FLIP;
         // A strict compare means a tie keeps the left entry, which has the lower index.
         assign w_b_better = w_mode ? (w_b_key > w_a_key) : (w_b_key < w_a_key);
         assign w_pick_b   = w_b_prs & (~w_a_prs | w_b_better);

         // Register the winner of the pair. A lone present entry always wins.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_node_val[C_NODE] <= '0;
               r_node_idx[C_NODE] <= '0;
               r_node_prs[C_NODE] <= 1'b0;
            end else if (w_adv) begin
               r_node_val[C_NODE] <= w_pick_b ? w_b_val : w_a_val;
               r_node_idx[C_NODE] <= w_pick_b ? w_b_idx : w_a_idx;
               r_node_prs[C_NODE] <= w_a_prs | w_b_prs;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_min_max_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_min_max_tree
//  Description : Scoreboard bench for min_max_tree. It covers four
//                configurations: N=3 unsigned, N=4 signed, N=4 unsigned and
//                N=5 unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_min_max_tree;

   localparam int NCFG = 4;

   typedef struct {
      logic [7:0] val;
      int         idx;
      int         cyc;
      bit         chk_lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cycle = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic       in_valid  [NCFG];
   logic       out_ready [NCFG];
   logic       mode_in   [NCFG];
   logic [7:0] lanes     [NCFG][16];
   bit         lat_chk   [NCFG];

   logic       ov   [NCFG];
   logic       ir   [NCFG];
   logic [7:0] od   [NCFG];
   logic [3:0] oi   [NCFG];
   logic       pend [NCFG];

   always #5 clk = ~clk;

   // Free-running cycle count, used for latency measurement.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: scan the lanes linearly. On a tie the earliest lane is kept.
   function automatic void ref_pick(input logic [7:0] ln [16], input int n, input bit sgn,
                                    input bit md, output logic [7:0] v, output int ix);
      int best, cur;
      ix = 0;
      for (int i = 1; i < n; i++) begin
         best = sgn ? int'($signed(ln[ix])) : int'(ln[ix]);
         cur  = sgn ? int'($signed(ln[i]))  : int'(ln[i]);
         if (md ? (cur > best) : (cur < best)) ix = i;
      end
      v = ln[ix];
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int NN = (g == 0) ? 3 : (g == 3) ? 5 : 4;
      localparam int SG = (g == 1) ? 1 : 0;
      localparam int LL = $clog2(NN);

      logic [NN*8-1:0] din;
      logic            dut_valid, dut_ready;
      logic [7:0]      dut_data;
      logic [LL-1:0]   dut_idx;
      exp_t            q[$];
      int              pushed = 0;
      int              popped = 0;
      logic            stalled = 1'b0;
      logic [7:0]      held_val = '0;
      logic [LL-1:0]   held_idx = '0;

      always_comb begin
         din = '0;
         for (int i = 0; i < NN; i++) din[i*8 +: 8] = lanes[g][i];
      end

      min_max_tree #(.WIDTH(8), .N(NN), .SIGNED(SG)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (dut_ready),
         .in_data   (din),
         .mode      (mode_in[g]),
         .out_valid (dut_valid),
         .out_ready (out_ready[g]),
         .out_data  (dut_data),
         .out_idx   (dut_idx)
      );

      assign ov[g]   = dut_valid;
      assign ir[g]   = dut_ready;
      assign od[g]   = dut_data;
      assign oi[g]   = 4'(dut_idx);
      assign pend[g] = (pushed != popped);

      // Scoreboard push: the edge that follows will accept the sample.
      always @(negedge clk) begin
         if (rst_n && in_valid[g] && dut_ready) begin
            exp_t       e;
            logic [7:0] v;
            int         ix;
            ref_pick(lanes[g], NN, SG != 0, mode_in[g], v, ix);
            e.val     = v;
            e.idx     = ix;
            e.cyc     = cycle;
            e.chk_lat = lat_chk[g];
            q.push_back(e);
            pushed <= pushed + 1;
         end
      end

      // Monitor: compare every transferred result and check the output during stalls.
      always @(negedge clk) begin
         exp_t e;
         if (!rst_n) begin
            q.delete();
            popped  <= pushed;
            stalled <= 1'b0;
         end else begin
            if (stalled) begin
               chk($sformatf("cfg%0d_stall_valid_held", g), int'(dut_valid), 1);
               chk($sformatf("cfg%0d_stall_data_stable", g), int'(dut_data), int'(held_val));
               chk($sformatf("cfg%0d_stall_idx_stable", g), int'(dut_idx), int'(held_idx));
            end
            if (dut_valid && out_ready[g]) begin
               if (q.size() == 0) begin
                  chk($sformatf("cfg%0d_spurious_out_valid", g), int'(dut_valid), 0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("cfg%0d_data", g), int'(dut_data), int'(e.val));
                  chk($sformatf("cfg%0d_idx", g), int'(dut_idx), e.idx);
                  if (e.chk_lat) chk($sformatf("cfg%0d_latency", g), cycle - e.cyc, LL);
                  popped <= popped + 1;
               end
            end
            if (dut_valid && !out_ready[g]) begin
               chk($sformatf("cfg%0d_in_ready_in_stall", g), int'(dut_ready), 0);
               stalled  <= 1'b1;
               held_val <= dut_data;
               held_idx <= dut_idx;
            end else begin
               stalled <= 1'b0;
            end
         end
      end
   end

   task automatic set5(input int c, input logic [7:0] a0, a1, a2, a3, a4);
      lanes[c][0] = a0; lanes[c][1] = a1; lanes[c][2] = a2;
      lanes[c][3] = a3; lanes[c][4] = a4;
   endtask

   task automatic rand_lanes(input int c);
      bit ties = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 16; i++)
         lanes[c][i] = ties ? 8'($urandom_range(0, 3)) : 8'($urandom);
   endtask

   // Offer the current lanes of config c until they are accepted. Returns just after the accepting edge.
   task automatic send(input int c, input bit md);
      int w = 0;
      mode_in[c]  = md;
      in_valid[c] = 1'b1;
      @(negedge clk);
      while (!ir[c] && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!ir[c]) chk($sformatf("cfg%0d_accept_timeout", c), int'(ir[c]), 1);
      @(posedge clk);
      #1;
      in_valid[c] = 1'b0;
   endtask

   task automatic drain(input int c);
      int w = 0;
      while (pend[c] && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (pend[c]) chk($sformatf("cfg%0d_drain_timeout", c), int'(pend[c]), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < NCFG; c++) begin
         in_valid[c] = 1'b0; out_ready[c] = 1'b1; mode_in[c] = 1'b0; lat_chk[c] = 1'b1;
         for (int i = 0; i < 16; i++) lanes[c][i] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", int'(ov[0]), 0);
      chk("reset_out_data", int'(od[0]), 0);
      chk("reset_out_idx", int'(oi[0]), 0);
      chk("reset_out_valid_n5", int'(ov[3]), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("in_ready_after_reset", int'(ir[0]), 1);

      // Basic minimum, mode switch, full tie, then alternating modes back to back.
      set5(0, 8'h20, 8'h10, 8'h30, 8'h00, 8'h00);
      send(0, 1'b0);
      send(0, 1'b1);
      set5(0, 8'h55, 8'h55, 8'h55, 8'h00, 8'h00);
      send(0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         rand_lanes(0);
         send(0, k[0]);
      end
      drain(0);

      // Signed and unsigned compares on the same lanes, odd-N pass-through, then random traffic.
      fork
         begin
            set5(1, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h00);
            send(1, 1'b0);
            send(1, 1'b1);
            for (int k = 0; k < 15; k++) begin rand_lanes(1); send(1, 1'($urandom_range(0, 1))); end
         end
         begin
            set5(2, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h00);
            send(2, 1'b0);
            send(2, 1'b1);
            for (int k = 0; k < 15; k++) begin rand_lanes(2); send(2, 1'($urandom_range(0, 1))); end
         end
         begin
            set5(3, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01);
            send(3, 1'b0);
            set5(3, 8'h80, 8'h80, 8'h80, 8'h80, 8'hF0);
            send(3, 1'b1);
            for (int k = 0; k < 15; k++) begin rand_lanes(3); send(3, 1'($urandom_range(0, 1))); end
         end
      join
      drain(1); drain(2); drain(3);

      // Backpressure: six samples streamed while out_ready drops for three cycles.
      lat_chk[0] = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) begin rand_lanes(0); send(0, 1'($urandom_range(0, 1))); end
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready[0] = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready[0] = 1'b1;
         end
      join
      drain(0);

      // Random gaps on the input and random backpressure on the output.
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               rand_lanes(0);
               send(0, 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int k = 0; k < 80; k++) begin
               @(posedge clk);
               #1 out_ready[0] = ($urandom_range(0, 3) != 0);
            end
            out_ready[0] = 1'b1;
         end
      join
      out_ready[0] = 1'b1;
      drain(0);

      // Reset while two samples are in flight, one of them held at the output.
      lat_chk[0]   = 1'b1;
      out_ready[0] = 1'b0;
      rand_lanes(0);
      send(0, 1'b0);
      rand_lanes(0);
      send(0, 1'b1);
      chk("inflight_out_valid_before_reset", int'(ov[0]), 1);
      #1 rst_n = 1'b0;
      #1 chk("reset_drops_out_valid", int'(ov[0]), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_stale_after_reset", int'(ov[0]), 0);
      end
      @(posedge clk);
      #1;
      set5(0, 8'h44, 8'h22, 8'h33, 8'h00, 8'h00);
      send(0, 1'b0);
      drain(0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
